// File: rtl/front_panel_seq.sv
// front_panel_seq: Altair front-panel EXAMINE/DEPOSIT sequencer that injects
// opcode/address bytes onto the CPU data-in path and issues panel memory writes.
module front_panel_seq #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] JMP_OPCODE = 8'hC3,
    parameter logic [DATA_WIDTH-1:0] NOP_OPCODE = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rd,
    input  logic                  examine,
    input  logic                  examine_next,
    input  logic                  deposit,
    input  logic                  deposit_next,
    input  logic [ADDR_WIDTH-1:0] sw_addr,
    input  logic [DATA_WIDTH-1:0] sw_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  inject,
    output logic                  busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [ADDR_WIDTH-1:0] cur_addr
);
    localparam int AB = ADDR_WIDTH / DATA_WIDTH;
    localparam int IW = $clog2(AB + 1);

    typedef enum logic [1:0] {IDLE, SEND, WRITE} state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  exam_q, exam_d;
    logic                  dn_q, dn_d;
    logic [ADDR_WIDTH-1:0] sh_q, sh_d;
    logic                  prev_rd_q, prev_rd_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  inject_q, inject_d;
    logic                  busy_q, busy_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic                  fall;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exam_d      = exam_q;
        dn_d        = dn_q;
        sh_d        = sh_q;
        data_out_d  = data_out_q;
        inject_d    = inject_q;
        busy_d      = busy_q;
        mem_wdata_d = mem_wdata_q;
        cur_addr_d  = cur_addr_q;
        mem_we_d    = 1'b0;
        prev_rd_d   = rd;
        fall        = prev_rd_q & ~rd;
        case (state_q)
            IDLE: begin
                if (examine) begin
                    state_d    = SEND;
                    exam_d     = 1'b1;
                    idx_d      = '0;
                    sh_d       = sw_addr;
                    cur_addr_d = sw_addr;
                    data_out_d = JMP_OPCODE;
                    inject_d   = 1'b1;
                    busy_d     = 1'b1;
                end else if (examine_next || deposit_next) begin
                    state_d    = SEND;
                    exam_d     = 1'b0;
                    dn_d       = ~examine_next;
                    idx_d      = '0;
                    data_out_d = NOP_OPCODE;
                    inject_d   = 1'b1;
                    busy_d     = 1'b1;
                    if (!examine_next) mem_wdata_d = sw_data;
                end else if (deposit) begin
                    state_d     = WRITE;
                    mem_we_d    = 1'b1;
                    busy_d      = 1'b1;
                    mem_wdata_d = sw_data;
                end
            end
            SEND: begin
                // The captured address is shifted out low byte first, one byte per fall.
                if (fall && exam_q && idx_q != IW'(AB)) begin
                    idx_d      = idx_q + 1'b1;
                    data_out_d = sh_q[DATA_WIDTH-1:0];
                    sh_d       = sh_q >> DATA_WIDTH;
                end else if (fall) begin
                    inject_d   = 1'b0;
                    cur_addr_d = exam_q ? cur_addr_q : cur_addr_q + 1'b1;
                    state_d    = (!exam_q && dn_q) ? WRITE : IDLE;
                    mem_we_d   = !exam_q && dn_q;
                    busy_d     = !exam_q && dn_q;
                end
            end
            WRITE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            exam_q      <= 1'b0;
            dn_q        <= 1'b0;
            sh_q        <= '0;
            prev_rd_q   <= 1'b0;
            data_out_q  <= '0;
            inject_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            cur_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            exam_q      <= exam_d;
            dn_q        <= dn_d;
            sh_q        <= sh_d;
            prev_rd_q   <= prev_rd_d;
            data_out_q  <= data_out_d;
            inject_q    <= inject_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            cur_addr_q  <= cur_addr_d;
        end
    end

    assign data_out  = data_out_q;
    assign inject    = inject_q;
    assign busy      = busy_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = cur_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cur_addr  = cur_addr_q;
endmodule

// File: tb/tb_front_panel_seq.sv
// tb_front_panel_seq: directed and randomized command sequences against a
// transaction-level model of the front-panel sequencer.
module tb_front_panel_seq;
    logic        clk = 0, reset_n = 0, rd = 0;
    logic        examine = 0, examine_next = 0, deposit = 0, deposit_next = 0;
    logic [15:0] sw_addr = 0;
    logic [7:0]  sw_data = 0;
    logic [7:0]  data_out, mem_wdata;
    logic        inject, busy, mem_we;
    logic [15:0] mem_addr, cur_addr;

    logic        rd2 = 0, ex2 = 0;
    logic [23:0] sw_addr2 = 0;
    logic [7:0]  data_out2, mem_wdata2;
    logic        inject2, busy2, mem_we2;
    logic [23:0] mem_addr2, cur_addr2;

    int          n_cmp = 0, n_err = 0, we_cnt = 0, wr_exp = 0;
    logic [15:0] m_cur = 0;

    front_panel_seq dut (
        .clk(clk), .reset_n(reset_n), .rd(rd), .examine(examine), .examine_next(examine_next),
        .deposit(deposit), .deposit_next(deposit_next), .sw_addr(sw_addr), .sw_data(sw_data),
        .data_out(data_out), .inject(inject), .busy(busy), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cur_addr(cur_addr)
    );

    front_panel_seq #(.ADDR_WIDTH(24)) dut24 (
        .clk(clk), .reset_n(reset_n), .rd(rd2), .examine(ex2), .examine_next(1'b0),
        .deposit(1'b0), .deposit_next(1'b0), .sw_addr(sw_addr2), .sw_data(8'h00),
        .data_out(data_out2), .inject(inject2), .busy(busy2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .cur_addr(cur_addr2)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    // One rd pulse; optionally fires stray commands and switch changes that must be ignored.
    task automatic rd_pulse(input bit noise);
        rd = 1;
        if (noise) begin
            {examine, examine_next, deposit_next, deposit} = 4'($urandom_range(1, 15));
            sw_addr = 16'($urandom);
            sw_data = 8'($urandom);
        end
        step;
        {examine, examine_next, deposit_next, deposit} = 4'b0;
        rd = 0;
        step;
    endtask

    // cmd = {examine, examine_next, deposit_next, deposit}
    task automatic run(input logic [3:0] cmd, input logic [15:0] a, input logic [7:0] d, input bit noise);
        logic [7:0] bytes[$];
        bit         wr;
        bytes = {};
        wr = 0;
        if (cmd[3]) begin
            bytes.push_back(8'hC3);
            for (int k = 0; k < 2; k++) bytes.push_back(8'(a >> (8 * k)));
            m_cur = a;
        end else if (cmd[2]) begin
            bytes.push_back(8'h00);
            m_cur = m_cur + 16'd1;
        end else if (cmd[1]) begin
            bytes.push_back(8'h00);
            m_cur = m_cur + 16'd1;
            wr = 1;
        end else if (cmd[0]) wr = 1;
        sw_addr = a;
        sw_data = d;
        {examine, examine_next, deposit_next, deposit} = cmd;
        step;
        {examine, examine_next, deposit_next, deposit} = 4'b0;
        check("busy_accept", busy, 1);
        foreach (bytes[i]) begin
            check("inject", inject, 1);
            check("data_out", data_out, bytes[i]);
            rd_pulse(noise);
        end
        check("inject_end", inject, 0);
        if (wr) begin
            check("mem_we", mem_we, 1);
            check("busy_write", busy, 1);
            check("mem_addr", mem_addr, m_cur);
            check("mem_wdata", mem_wdata, d);
            wr_exp++;
            step;
            check("mem_we_off", mem_we, 0);
        end
        check("busy_end", busy, 0);
        check("cur_addr", cur_addr, m_cur);
        check("write_count", we_cnt, wr_exp);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_inject"}, inject, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_cur_addr"}, cur_addr, 0);
    endtask

    initial begin
        logic [7:0]  e24[4];
        logic [15:0] a;
        e24 = '{8'hC3, 8'hEF, 8'hCD, 8'hAB};
        repeat (3) step;
        check_zero("reset");
        reset_n = 1;
        step;

        run(4'b1000, 16'h1234, 8'h00, 0);
        run(4'b0100, 16'h0000, 8'h00, 0);
        run(4'b0001, 16'h0000, 8'hAA, 0);
        run(4'b1000, 16'hFFFF, 8'h00, 0);
        run(4'b0010, 16'h0000, 8'h55, 0);
        check("wrap_addr", cur_addr, 16'h0000);
        run(4'b1000, 16'hBEEF, 8'h00, 1);
        run(4'b1001, 16'h4321, 8'h77, 0);

        sw_addr = 16'h1234;
        examine = 1;
        step;
        examine = 0;
        check("rst_seq_b0", data_out, 8'hC3);
        rd_pulse(0);
        check("rst_seq_b1", data_out, 8'h34);
        reset_n = 0;
        step;
        check_zero("midreset");
        reset_n = 1;
        m_cur = 0;
        step;
        run(4'b1000, 16'h1234, 8'h00, 0);

        for (int n = 0; n < 150; n++) begin
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF - 16'($urandom_range(0, 1)) : 16'($urandom);
            run(4'($urandom_range(1, 15)), a, 8'($urandom), $urandom_range(0, 3) == 0);
        end

        sw_addr2 = 24'hABCDEF;
        ex2 = 1;
        step;
        ex2 = 0;
        sw_addr2 = 24'h000000;
        for (int k = 0; k < 4; k++) begin
            check("w24_inject", inject2, 1);
            check("w24_data", data_out2, e24[k]);
            rd2 = 1;
            step;
            rd2 = 0;
            step;
        end
        check("w24_inject_end", inject2, 0);
        check("w24_busy_end", busy2, 0);
        check("w24_cur_addr", cur_addr2, 24'hABCDEF);
        check("w24_mem_addr", mem_addr2, 24'hABCDEF);
        check("w24_mem_we", mem_we2, 0);
        check("w24_mem_wdata", mem_wdata2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
